// File: rtl/pc_pkg.sv
// Shared types for the program counter / return-stack block.
// The command enum is the outcome of the per-cycle priority decode.
package pc_pkg;

   localparam int PC_WIDTH = 16;
   localparam int PC_DEPTH = 8;

   typedef enum logic [2:0] {
      PC_RESET = 3'd0,
      PC_POP   = 3'd1,
      PC_LOAD  = 3'd2,
      PC_INC   = 3'd3,
      PC_HOLD  = 3'd4
   } pc_cmd_t;

   // Priority: reset > pop > load > inc > hold.
   function automatic pc_cmd_t pc_decode(input logic rst, input logic pop,
                                         input logic load, input logic inc);
      if (rst)       return PC_RESET;
      else if (pop)  return PC_POP;
      else if (load) return PC_LOAD;
      else if (inc)  return PC_INC;
      else           return PC_HOLD;
   endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Fetch-path control/status bundle between the jump mux side and the PC.
interface pc_stack_if #(
   parameter int WIDTH = pc_pkg::PC_WIDTH,
   parameter int DEPTH = pc_pkg::PC_DEPTH
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] in;
   logic             load;
   logic             inc;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] out;
   logic [DW-1:0]    depth;
   logic             empty;
   logic             full;
   logic             err;

   modport master (
      output in, load, inc, push, pop,
      input  out, depth, empty, full, err
   );

   modport slave (
      input  in, load, inc, push, pop,
      output out, depth, empty, full, err
   );
endinterface

// File: rtl/pc_stack_ret_stack.sv
// DEPTH x WIDTH return-address LIFO. Pop wins over push; a push in the
// same cycle as a pop, or into a full stack, is dropped.
module ret_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] top_o,
   output logic [AW:0]      depth_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             over_o,
   output logic             under_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      depth_q, depth_d;
   logic [AW-1:0]    wr_idx, top_idx;
   logic             do_push, do_pop;

   assign empty_o = (depth_q == '0);
   assign full_o  = (depth_q == (AW+1)'(DEPTH));

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & ~pop_i & ~full_o;

   assign over_o  = push_i & ~pop_i & full_o;
   assign under_o = pop_i & empty_o;

   // A full stack has depth_q[AW-1:0]==0, so the decrement wraps to DEPTH-1.
   assign wr_idx  = depth_q[AW-1:0];
   assign top_idx = depth_q[AW-1:0] - AW'(1);

   assign top_o   = mem_q[top_idx];
   assign depth_o = depth_q;

   always_comb begin
      depth_d = depth_q;
      if (do_pop)
         depth_d = depth_q - (AW+1)'(1);
      else if (do_push)
         depth_d = depth_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (srst)
         depth_q <= '0;
      else
         depth_q <= depth_d;
   end

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (!srst && do_push)
         mem_q[wr_idx] <= din_i;
   end

endmodule

// File: rtl/pc_stack.sv
// Program counter with integrated return-address stack. Holds the PC
// register, the per-cycle priority decode and the sticky error flag.
module pc_stack
   import pc_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH,
   parameter int DEPTH = PC_DEPTH
) (
   input logic         clk,
   input logic         reset,
   pc_stack_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] pc_plus1;
   logic [WIDTH-1:0] stk_top;
   logic [AW:0]      stk_depth;
   logic             stk_full, stk_empty, stk_over, stk_under;
   pc_cmd_t          cmd;

   assign pc_plus1 = pc_q + WIDTH'(1);
   assign cmd      = pc_decode(reset, bus.pop, bus.load, bus.inc);

   ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk     (clk),
      .srst    (reset),
      .push_i  (bus.push),
      .pop_i   (bus.pop),
      .din_i   (pc_plus1),
      .top_o   (stk_top),
      .depth_o (stk_depth),
      .full_o  (stk_full),
      .empty_o (stk_empty),
      .over_o  (stk_over),
      .under_o (stk_under)
   );

   always_comb begin
      pc_d = pc_q;
      unique case (cmd)
         PC_RESET: pc_d = '0;
         PC_POP:   if (!stk_empty) pc_d = stk_top;
         PC_LOAD:  pc_d = bus.in;
         PC_INC:   pc_d = pc_plus1;
         default:  pc_d = pc_q;
      endcase
   end

   // Push alongside pop is a conflict even when the pop itself is legal.
   always_comb begin
      err_d = err_q;
      if (stk_over || stk_under || (bus.push && bus.pop))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   assign bus.out   = pc_q;
   assign bus.depth = stk_depth;
   assign bus.empty = stk_empty;
   assign bus.full  = stk_full;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: a vector table plus hand-written sequences
// for overflow, push/pop conflict and mid-stack reset.
module tb_pc_stack;
   import pc_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   pc_stack_if #(.WIDTH(16), .DEPTH(8)) bus ();

   pc_stack #(.WIDTH(16), .DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        load;
      logic        inc;
      logic        push;
      logic        pop;
      logic [15:0] din;
      logic [15:0] e_out;
      logic [3:0]  e_depth;
      logic        e_empty;
      logic        e_full;
      logic        e_err;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic r, input logic l, input logic i,
                               input logic pu, input logic po, input logic [15:0] d,
                               input logic [15:0] eo, input logic [3:0] ed,
                               input logic ee, input logic ef, input logic er);
      vec_t v;
      v.rst = r; v.load = l; v.inc = i; v.push = pu; v.pop = po; v.din = d;
      v.e_out = eo; v.e_depth = ed; v.e_empty = ee; v.e_full = ef; v.e_err = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive at the negedge, let one posedge pass, sample at the next negedge.
   task automatic cyc(input logic r, input logic l, input logic i, input logic pu,
                      input logic po, input logic [15:0] d);
      reset    = r;
      bus.load = l;
      bus.inc  = i;
      bus.push = pu;
      bus.pop  = po;
      bus.in   = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_all(input string tag, input logic [15:0] eo, input logic [3:0] ed,
                             input logic ee, input logic ef, input logic er);
      $display("%s: out=%04h depth=%0d empty=%0b full=%0b err=%0b",
               tag, bus.out, bus.depth, bus.empty, bus.full, bus.err);
      chk({tag, ".out"},   32'(bus.out),   32'(eo));
      chk({tag, ".depth"}, 32'(bus.depth), 32'(ed));
      chk({tag, ".empty"}, 32'(bus.empty), 32'(ee));
      chk({tag, ".full"},  32'(bus.full),  32'(ef));
      chk({tag, ".err"},   32'(bus.err),   32'(er));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.load = 0; bus.inc = 0; bus.push = 0; bus.pop = 0; bus.in = '0;

      //                 rst ld inc psh pop  in       out     d  e  f  err
      vecs[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      vecs[1]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 1, 0, 0);
      vecs[2]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0002, 0, 1, 0, 0);
      vecs[3]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0003, 0, 1, 0, 0);
      vecs[4]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0004, 0, 1, 0, 0);
      vecs[5]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0005, 0, 1, 0, 0);
      vecs[6]  = mk(0, 1, 0, 1, 0, 16'h0100, 16'h0100, 1, 0, 0, 0);
      vecs[7]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0101, 1, 0, 0, 0);
      vecs[8]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0102, 1, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0006, 0, 1, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0006, 0, 1, 0, 1);
      vecs[11] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0006, 0, 1, 0, 1);
      vecs[12] = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      vecs[13] = mk(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 0, 0);
      vecs[14] = mk(0, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 1, 0, 0, 0);
      vecs[15] = mk(0, 1, 0, 0, 0, 16'h1234, 16'h1234, 1, 0, 0, 0);
      vecs[16] = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0);
      vecs[17] = mk(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 1, 0, 0);
      vecs[18] = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      vecs[19] = mk(0, 1, 0, 0, 0, 16'h00AA, 16'h00AA, 0, 1, 0, 0);
      vecs[20] = mk(1, 1, 1, 1, 0, 16'h00BB, 16'h0000, 0, 1, 0, 0);
      vecs[21] = mk(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 1);
      vecs[22] = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 1, 0, 1);
      vecs[23] = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);

      @(negedge clk);
      for (int k = 0; k < 24; k++) begin
         cyc(vecs[k].rst, vecs[k].load, vecs[k].inc, vecs[k].push, vecs[k].pop, vecs[k].din);
         expect_all($sformatf("vec%0d", k), vecs[k].e_out, vecs[k].e_depth,
                    vecs[k].e_empty, vecs[k].e_full, vecs[k].e_err);
      end

      // Fill to DEPTH from 0x10, then one overflowing push.
      cyc(1, 0, 0, 0, 0, 16'h0);
      cyc(0, 1, 0, 0, 0, 16'h0010);
      for (int k = 1; k <= 8; k++) begin
         cyc(0, 0, 1, 1, 0, 16'h0);
         expect_all($sformatf("fill%0d", k), 16'(16'h0010 + k), 4'(k),
                    1'b0, (k == 8), 1'b0);
      end
      cyc(0, 0, 1, 1, 0, 16'h0);
      expect_all("overflow", 16'h0019, 4'd8, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         cyc(0, 0, 0, 0, 1, 16'h0);
         expect_all($sformatf("drain%0d", k), 16'(16'h0018 - k), 4'(7 - k),
                    (k == 7), 1'b0, 1'b1);
      end

      // Push+pop conflict at depth 3, then reset with everything asserted.
      cyc(1, 0, 0, 0, 0, 16'h0);
      cyc(0, 1, 0, 0, 0, 16'h0020);
      for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 1, 0, 16'h0);
      expect_all("d3", 16'h0023, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc(0, 0, 0, 1, 1, 16'h0);
      expect_all("pushpop", 16'h0023, 4'd2, 1'b0, 1'b0, 1'b1);
      cyc(0, 0, 0, 0, 1, 16'h0);
      expect_all("pop_after", 16'h0022, 4'd1, 1'b0, 1'b0, 1'b1);
      cyc(1, 1, 1, 1, 1, 16'h0077);
      expect_all("midreset", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      cyc(0, 1, 0, 1, 0, 16'h0050);
      expect_all("call0", 16'h0050, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc(0, 0, 0, 0, 1, 16'h0);
      expect_all("ret0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
